// File: rtl/fpu_lib.sv
// Shared FP16 library package.
// Provides the significand width derived from `FP16_FRACW and the state
// encoding of the sequential radix-4 significand multiplier.
// Optional build macro used by fpu_sig_mul_r4: FPU_SIGMUL_EARLY_TERM_EN.
`ifndef FP16_FRACW
`define FP16_FRACW 10
`endif

package fpu_lib;

    // Significand width including the implicit bit.
    localparam int unsigned FP16_SIGW = `FP16_FRACW + 1;

    typedef enum logic [1:0] {
        SM_IDLE,
        SM_BUSY,
        SM_DONE
    } fpuSigMulState_t;

endpackage

// File: rtl/fpu_sig_mul_pp.sv
// Radix-4 partial-product select for the significand multiplier.
// Ports:
//   digit      - current 2-bit multiplier digit
//   mcand      - aligned multiplicand (1x)
//   m3         - aligned 3x multiplicand
//   partProd_c - combinational partial product 0 / 1x / 2x / 3x
module fpu_sig_mul_pp #(
    parameter int unsigned SIGW = 11
) (
    input  logic [1:0]        digit,
    input  logic [2*SIGW:0]   mcand,
    input  logic [2*SIGW:0]   m3,
    output logic [2*SIGW+1:0] partProd_c
);

    localparam int unsigned ACCW = 2 * SIGW + 2;

    // Pick the multiple of the multiplicand selected by the digit.
    always_comb begin
        partProd_c = '0;
        case (digit)
            2'd1:    partProd_c = ACCW'(mcand);
            2'd2:    partProd_c = {mcand, 1'b0};
            2'd3:    partProd_c = ACCW'(m3);
            default: partProd_c = '0;
        endcase
    end

endmodule

// File: rtl/fpu_sig_mul_r4.sv
// Sequential radix-4 significand multiplier for the FP16 multiply datapath.
// Retires two multiplier bits per cycle and returns the full unnormalized
// product {int[1:0], frac} through a start/done handshake.
// Optional macro FPU_SIGMUL_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are all zero (latency 1..ITER instead of fixed ITER).
// Ports:
//   clock, reset - clock and asynchronous active-high reset
//   start        - request, sampled only in SM_IDLE / SM_DONE
//   mulIn1       - multiplicand significand
//   mulIn2       - multiplier significand
//   mulOut       - registered product, valid while done
//   done         - product valid, held until next accepted start
//   busy         - iteration in progress
module fpu_sig_mul_r4
    import fpu_lib::*;
#(
    parameter int unsigned SIGW = FP16_SIGW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [SIGW-1:0]   mulIn1,
    input  logic [SIGW-1:0]   mulIn2,
    output logic [2*SIGW-1:0] mulOut,
    output logic              done,
    output logic              busy
);

    localparam int unsigned ITER = (SIGW + 1) / 2;
    localparam int unsigned MCW  = 2 * SIGW + 1;
    localparam int unsigned ACCW = 2 * SIGW + 2;
    localparam int unsigned MPW  = 2 * ITER;
    localparam int unsigned CNTW = $clog2(ITER + 1);

    fpuSigMulState_t state, stateNext;

    logic [MCW-1:0]  mcand;
    logic [MCW-1:0]  m3;
    logic [MPW-1:0]  mplier;
    logic [ACCW-1:0] acc;
    logic [CNTW-1:0] cnt;

    logic [ACCW-1:0] partProd_c;
    logic [ACCW-1:0] accNext;
    logic [MPW-1:0]  mplierShift;
    logic            accept;
    logic            finish;

    fpu_sig_mul_pp #(
        .SIGW (SIGW)
    ) u_pp (
        .digit      (mplier[1:0]),
        .mcand      (mcand),
        .m3         (m3),
        .partProd_c (partProd_c)
    );

    assign accNext     = acc + partProd_c;
    assign mplierShift = mplier >> 2;

    // Next-state and handshake decode.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            SM_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    stateNext = SM_BUSY;
                end
            end
            SM_BUSY: begin
`ifdef FPU_SIGMUL_EARLY_TERM_EN
                finish = (cnt == CNTW'(ITER - 1)) || (mplierShift == '0);
`else
                finish = (cnt == CNTW'(ITER - 1));
`endif
                if (finish) begin
                    stateNext = SM_DONE;
                end
            end
            SM_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    stateNext = SM_BUSY;
                end
            end
            default: stateNext = SM_IDLE;
        endcase
    end

    // State register with registered status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SM_IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= stateNext;
            done  <= (stateNext == SM_DONE);
            busy  <= (stateNext == SM_BUSY);
        end
    end

    // Operand latch, shift-and-add iteration and product capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            m3     <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            mulOut <= '0;
        end else if (accept) begin
            mcand  <= MCW'(mulIn1);
            m3     <= MCW'(mulIn1) + (MCW'(mulIn1) << 1);
            mplier <= MPW'(mulIn2);
            acc    <= '0;
            cnt    <= '0;
        end else if (state == SM_BUSY) begin
            acc    <= accNext;
            mcand  <= mcand << 2;
            m3     <= m3 << 2;
            mplier <= mplierShift;
            cnt    <= CNTW'(cnt + 1'b1);
            if (finish) begin
                mulOut <= accNext[2*SIGW-1:0];
            end
        end
    end

    // A product of two SIGW-bit operands never reaches the top two acc bits.
    accUpperZero: assert property (
        @(posedge clock) disable iff (reset)
        (state == SM_BUSY && finish) |-> (accNext[ACCW-1:ACCW-2] == 2'b00)
    );

endmodule

// File: tb/tb_fpu_sig_mul_r4.sv
// Self-checking bench for fpu_sig_mul_r4: vector table, corner sequences
// (mid-operation reset, ignored start, held start restart) and random pairs,
// with expected products held in a scoreboard queue.
module tb_fpu_sig_mul_r4;

    localparam int unsigned SIGW = 11;
    localparam int unsigned ITER = (SIGW + 1) / 2;
    localparam int unsigned PW   = 2 * SIGW;

    logic            clock;
    logic            reset;
    logic            start;
    logic [SIGW-1:0] mulIn1;
    logic [SIGW-1:0] mulIn2;
    logic [PW-1:0]   mulOut;
    logic            done;
    logic            busy;

    int nChecks;
    int nFail;

    logic [PW-1:0] expQ[$];

    typedef struct {
        logic [SIGW-1:0] a;
        logic [SIGW-1:0] b;
        logic [PW-1:0]   p;
    } vec_t;

    vec_t vecs[8];

    fpu_sig_mul_r4 dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .mulIn1 (mulIn1),
        .mulIn2 (mulIn2),
        .mulOut (mulOut),
        .done   (done),
        .busy   (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Edges from the accept edge until done is first seen high.
    function automatic int expLat(input logic [SIGW-1:0] b);
`ifdef FPU_SIGMUL_EARLY_TERM_EN
        int k;
        logic [15:0] bw;
        bw = 16'(b);
        k = 1;
        while ((bw >> (2 * k)) != 16'd0) k++;
        return k;
`else
        return (b === b) ? int'(ITER) : int'(ITER);
`endif
    endfunction

    task automatic waitDone(inout int lat);
        while (!done && lat < 30) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic runOp(input string name, input logic [SIGW-1:0] a,
                         input logic [SIGW-1:0] b, input logic [PW-1:0] p);
        int lat;
        logic [PW-1:0] e;
        @(negedge clock);
        mulIn1 = a;
        mulIn2 = b;
        start  = 1'b1;
        expQ.push_back(p);
        @(posedge clock);
        #1;
        start = 1'b0;
        check({name, "_busy"}, 64'(busy), 64'd1);
        lat = 0;
        waitDone(lat);
        check({name, "_lat"}, 64'(lat), 64'(expLat(b)));
        e = expQ.pop_front();
        check({name, "_prod"}, 64'(mulOut), 64'(e));
        check({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int lat;
        logic [PW-1:0] e;
        logic [SIGW-1:0] ra, rb;

        nChecks = 0;
        nFail   = 0;
        vecs[0] = '{11'h400, 11'h400, 22'h100000};
        vecs[1] = '{11'h7FF, 11'h7FF, 22'h3FF001};
        vecs[2] = '{11'h5A5, 11'h3C3, 22'h153BAF};
        vecs[3] = '{11'h000, 11'h5A5, 22'h000000};
        vecs[4] = '{11'h5A5, 11'h000, 22'h000000};
        vecs[5] = '{11'h400, 11'h600, 22'h180000};
        vecs[6] = '{11'h001, 11'h001, 22'h000001};
        vecs[7] = '{11'h7FF, 11'h003, 22'h0017FD};

        reset  = 1'b1;
        start  = 1'b0;
        mulIn1 = '0;
        mulIn2 = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_mulOut", 64'(mulOut), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);
        end

        // Reset in the middle of an operation.
        @(negedge clock);
        mulIn1 = 11'h7FF;
        mulIn2 = 11'h7FF;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_mulOut", 64'(mulOut), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        runOp("postrst", 11'h400, 11'h600, 22'h180000);

        // Start and operand changes while busy are ignored.
        @(negedge clock);
        mulIn1 = 11'h400;
        mulIn2 = 11'h400;
        start  = 1'b1;
        expQ.push_back(22'h100000);
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #1;
        mulIn1 = 11'h7FF;
        mulIn2 = 11'h7FF;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("ign_busy", 64'(busy), 64'd1);
        lat = 2;
        waitDone(lat);
        check("ign_lat", 64'(lat), 64'(ITER));
        e = expQ.pop_front();
        check("ign_prod", 64'(mulOut), 64'(e));

        // Start held in SM_DONE restarts immediately.
        mulIn1 = 11'h600;
        mulIn2 = 11'h600;
        start  = 1'b1;
        expQ.push_back(22'h240000);
        @(posedge clock);
        #1;
        start = 1'b0;
        check("restart_done_drop", 64'(done), 64'd0);
        check("restart_hold_prev", 64'(mulOut), 64'h100000);
        lat = 0;
        waitDone(lat);
        check("restart_lat", 64'(lat), 64'(expLat(11'h600)));
        e = expQ.pop_front();
        check("restart_prod", 64'(mulOut), 64'(e));

        for (int i = 0; i < 2000; i++) begin
            ra = SIGW'($urandom);
            rb = SIGW'($urandom);
            if (i % 16 == 0) rb = SIGW'($urandom_range(0, 15));
            runOp($sformatf("rnd%0d", i), ra, rb, PW'(ra) * PW'(rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
